// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: AluOp codes, opcode/funct
// values, state encodings and the datapath control word.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;

    // AluOp encodings; bit 2 steers the ALU into its logic unit
    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0100;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0101;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALU_NOR = 4'b0111;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_XOR  = 6'b100110;
    localparam logic [FUNCT_W-1:0] FN_NOR  = 6'b100111;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b101010;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_ALUWB  = 4'd8,
        S_IEXEC  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Which ALU operation source the current state uses
    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_ADD   = 3'd1,
        CLS_SUB   = 3'd2,
        CLS_RTYPE = 3'd3,
        CLS_ITYPE = 3'd4
    } alu_cls_t;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_write;
    } ctrl_t;

    function automatic logic is_imm_alu(input logic [OP_W-1:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational AluOp decode from the state's ALU class, the opcode and the funct field.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_cls_t             cls,
    input  logic [OP_W-1:0]      opcode,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALUOP_W-1:0]   alu_op,
    output logic                 funct_valid,
    output logic                 ext_zero
);

    logic [ALUOP_W-1:0] r_op;
    logic [ALUOP_W-1:0] i_op;

    always_comb begin
        r_op        = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD, FN_ADDU: r_op = ALU_ADD;
            FN_SUB, FN_SUBU: r_op = ALU_SUB;
            FN_AND:          r_op = ALU_AND;
            FN_OR:           r_op = ALU_OR;
            FN_XOR:          r_op = ALU_XOR;
            FN_NOR:          r_op = ALU_NOR;
            FN_SLT:          r_op = ALU_SLT;
            default:         funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        i_op = ALU_ADD;
        case (opcode)
            OP_SLTI: i_op = ALU_SLT;
            OP_ANDI: i_op = ALU_AND;
            OP_ORI:  i_op = ALU_OR;
            default: i_op = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_op   = ALU_ADD;
        ext_zero = 1'b0;
        case (cls)
            CLS_SUB:   alu_op = ALU_SUB;
            CLS_RTYPE: alu_op = r_op;
            CLS_ITYPE: begin
                alu_op   = i_op;
                ext_zero = (opcode == OP_ANDI) || (opcode == OP_ORI);
            end
            default:   alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multicycle MIPS datapath (Moore outputs, PCWrite uses Zero).
// Define MC_CTRL_BNE_EN to add bne (opcode 000101) as a branch on ~Zero.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      Opcode,
    input  logic [FUNCT_W-1:0]   Funct,
    input  logic                 Zero,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 MemtoReg,
    output logic                 RegDst,
    output logic                 RegWrite,
    output logic                 ExtZero,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [ALUOP_W-1:0]   AluOp,
    output logic [1:0]           PCSource,
    output logic                 PCWrite,
    output logic [STATE_W-1:0]   State
);

    state_t   state_q, state_d;
    logic     is_load_q, is_load_d;
    logic     is_rtype_q, is_rtype_d;
    ctrl_t    ctrl;
    alu_cls_t cls;
    logic     funct_valid;
    logic     branch_take;

`ifdef MC_CTRL_BNE_EN
    logic     is_bne_q, is_bne_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET;
            is_load_q  <= 1'b0;
            is_rtype_q <= 1'b0;
`ifdef MC_CTRL_BNE_EN
            is_bne_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            is_rtype_q <= is_rtype_d;
`ifdef MC_CTRL_BNE_EN
            is_bne_q   <= is_bne_d;
`endif
        end
    end

    // ALU operation source per state
    always_comb begin
        cls = CLS_NONE;
        case (state_q)
            S_FETCH, S_DECODE, S_MEMADR: cls = CLS_ADD;
            S_BRANCH:                    cls = CLS_SUB;
            S_REXEC:                     cls = CLS_RTYPE;
            S_IEXEC:                     cls = CLS_ITYPE;
            default:                     cls = CLS_NONE;
        endcase
    end

    mc_alu_decoder u_alu_dec (
        .cls         (cls),
        .opcode      (Opcode),
        .funct       (Funct),
        .alu_op      (AluOp),
        .funct_valid (funct_valid),
        .ext_zero    (ExtZero)
    );

`ifdef MC_CTRL_BNE_EN
    assign branch_take = is_bne_q ? ~Zero : Zero;
`else
    assign branch_take = Zero;
`endif

    // Next state and Moore control word
    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        is_rtype_d = is_rtype_q;
`ifdef MC_CTRL_BNE_EN
        is_bne_d   = is_bne_q;
`endif
        ctrl       = '0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                is_load_d      = (Opcode == OP_LW);
                is_rtype_d     = (Opcode == OP_RTYPE);
`ifdef MC_CTRL_BNE_EN
                is_bne_d       = (Opcode == OP_BNE);
`endif
                state_d        = S_FETCH;
                if ((Opcode == OP_LW) || (Opcode == OP_SW)) begin
                    state_d = S_MEMADR;
                end else if (Opcode == OP_RTYPE) begin
                    state_d = funct_valid ? S_REXEC : S_FETCH;
                end else if (is_imm_alu(Opcode)) begin
                    state_d = S_IEXEC;
                end else if (Opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                end else if (Opcode == OP_BNE) begin
                    state_d = S_BRANCH;
`endif
                end else if (Opcode == OP_J) begin
                    state_d = S_JUMP;
                end
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = is_load_q ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                state_d       = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                state_d        = S_FETCH;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                state_d        = S_ALUWB;
            end
            S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = is_rtype_q;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = branch_take;
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
                state_d        = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign IorD     = ctrl.iord;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegDst   = ctrl.reg_dst;
    assign RegWrite = ctrl.reg_write;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign PCSource = ctrl.pc_source;
    assign PCWrite  = ctrl.pc_write;
    assign State    = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; honours MC_CTRL_BNE_EN the same way as the design.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ExtZero, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] AluOp;
    logic       PCWrite;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    // state numbers as encoded in the package
    localparam logic [3:0] ST_RESET = 4'd0,  ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_MEMADR = 4'd3,
                           ST_MEMRD = 4'd4,  ST_MEMWB = 4'd5, ST_MEMWR = 4'd6,  ST_REXEC = 4'd7,
                           ST_ALUWB = 4'd8,  ST_IEXEC = 4'd9, ST_BRANCH = 4'd10, ST_JUMP = 4'd11;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ExtZero(ExtZero),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AluOp(AluOp), .PCSource(PCSource),
        .PCWrite(PCWrite), .State(State)
    );

    always #5 clk = ~clk;

    logic [17:0] outs;
    assign outs = {IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ExtZero,
                   ALUSrcA, ALUSrcB, AluOp, PCSource, PCWrite};

    function automatic logic [17:0] mk(input logic iord, mr, mw, irw, m2r, rd, rw, ez, sa,
                                       input logic [1:0] sb, input logic [3:0] op,
                                       input logic [1:0] ps, input logic pw);
        return {iord, mr, mw, irw, m2r, rd, rw, ez, sa, sb, op, ps, pw};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] st, input logic [17:0] o);
        chk({tag, ".state"}, 32'(State), 32'(st));
        chk({tag, ".outs"}, 32'(outs), 32'(o));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [17:0] o_fetch, o_decode, o_memadr;

    initial begin
        o_fetch  = mk(0,1,0,1,0,0,0,0,0, 2'b01, 4'b0000, 2'b00, 1);
        o_decode = mk(0,0,0,0,0,0,0,0,0, 2'b11, 4'b0000, 2'b00, 0);
        o_memadr = mk(0,0,0,0,0,0,0,0,1, 2'b10, 4'b0000, 2'b00, 0);

        rst_n = 1'b0; Opcode = 6'b100011; Funct = 6'b000000; Zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_st("reset", ST_RESET, 18'd0);

        // lw: FETCH DECODE MEMADR MEMRD MEMWB, then back to FETCH
        rst_n = 1'b1;
        step(); chk_st("lw.fetch", ST_FETCH, o_fetch);
        step(); chk_st("lw.decode", ST_DECODE, o_decode);
        step(); chk_st("lw.memadr", ST_MEMADR, o_memadr);
        step(); chk_st("lw.memrd", ST_MEMRD, mk(1,1,0,0,0,0,0,0,0, 2'b00, 4'b0000, 2'b00, 0));
        step(); chk_st("lw.memwb", ST_MEMWB, mk(0,0,0,0,1,0,1,0,0, 2'b00, 4'b0000, 2'b00, 0));
        step(); chk_st("lw.done", ST_FETCH, o_fetch);

        // R-type sub
        Opcode = 6'b000000; Funct = 6'b100010;
        step(); chk_st("sub.decode", ST_DECODE, o_decode);
        step(); chk_st("sub.rexec", ST_REXEC, mk(0,0,0,0,0,0,0,0,1, 2'b00, 4'b0001, 2'b00, 0));
        step(); chk_st("sub.aluwb", ST_ALUWB, mk(0,0,0,0,0,1,1,0,0, 2'b00, 4'b0000, 2'b00, 0));
        step(); chk_st("sub.done", ST_FETCH, o_fetch);

        // R-type nor
        Funct = 6'b100111;
        step(); step(); chk("nor.aluop", 32'(AluOp), 32'h7);
        step(); step(); chk("nor.done", 32'(State), 32'(ST_FETCH));

        // unsupported funct: two-cycle NOP
        Funct = 6'b101011;
        step(); chk_st("badfn.decode", ST_DECODE, o_decode);
        step(); chk_st("badfn.fetch", ST_FETCH, o_fetch);

        // andi: zero-extended AND
        Opcode = 6'b001100; Funct = 6'b101011;
        step(); chk("andi.decode", 32'(State), 32'(ST_DECODE));
        step(); chk_st("andi.iexec", ST_IEXEC, mk(0,0,0,0,0,0,0,1,1, 2'b10, 4'b0100, 2'b00, 0));
        step(); chk_st("andi.aluwb", ST_ALUWB, mk(0,0,0,0,0,0,1,0,0, 2'b00, 4'b0000, 2'b00, 0));
        step(); chk("andi.done", 32'(State), 32'(ST_FETCH));

        // slti: sign-extended SLT
        Opcode = 6'b001010;
        step(); step(); chk_st("slti.iexec", ST_IEXEC, mk(0,0,0,0,0,0,0,0,1, 2'b10, 4'b0010, 2'b00, 0));
        step(); step(); chk("slti.done", 32'(State), 32'(ST_FETCH));

        // sw, aborted by reset while in MEMWR
        Opcode = 6'b101011;
        step(); chk("sw.decode", 32'(State), 32'(ST_DECODE));
        step(); chk_st("sw.memadr", ST_MEMADR, o_memadr);
        step(); chk_st("sw.memwr", ST_MEMWR, mk(1,0,1,0,0,0,0,0,0, 2'b00, 4'b0000, 2'b00, 0));
        rst_n = 1'b0;
        #1;
        chk_st("sw.abort", ST_RESET, 18'd0);
        #2;
        rst_n = 1'b1;
        step(); chk_st("rel.fetch", ST_FETCH, o_fetch);

        // beq taken then not taken (PCWrite follows Zero combinationally)
        Opcode = 6'b000100; Zero = 1'b1;
        step(); chk_st("beq.decode", ST_DECODE, o_decode);
        step(); chk_st("beq.taken", ST_BRANCH, mk(0,0,0,0,0,0,0,0,1, 2'b00, 4'b0001, 2'b01, 1));
        Zero = 1'b0;
        #1;
        chk_st("beq.nottaken", ST_BRANCH, mk(0,0,0,0,0,0,0,0,1, 2'b00, 4'b0001, 2'b01, 0));
        step(); chk_st("beq.done", ST_FETCH, o_fetch);

        // j
        Opcode = 6'b000010;
        step(); chk("j.decode", 32'(State), 32'(ST_DECODE));
        step(); chk_st("j.jump", ST_JUMP, mk(0,0,0,0,0,0,0,0,0, 2'b00, 4'b0000, 2'b10, 1));
        step(); chk("j.done", 32'(State), 32'(ST_FETCH));

        // bne
        Opcode = 6'b000101; Zero = 1'b0;
        step(); chk("bne.decode", 32'(State), 32'(ST_DECODE));
        step();
`ifdef MC_CTRL_BNE_EN
        chk_st("bne.taken", ST_BRANCH, mk(0,0,0,0,0,0,0,0,1, 2'b00, 4'b0001, 2'b01, 1));
        Zero = 1'b1;
        #1;
        chk("bne.nottaken", 32'(PCWrite), 32'h0);
        step(); chk("bne.done", 32'(State), 32'(ST_FETCH));
`else
        chk_st("bne.nop", ST_FETCH, o_fetch);
`endif

        // undefined opcode: NOP
        Opcode = 6'b111111;
        step(); step(); chk_st("illegal.nop", ST_FETCH, o_fetch);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
